// File: rtl/cmd_reply_packer.sv
// cmd_reply_packer: collects 16-bit control-reply words from the command
// reader and frames them into fixed-size inband USB packets on the control
// channel. A packet is a two-word header, a two-word timestamp, up to 252
// payload words and zero padding. The payload length is known only when the
// packet is closed, so reply words are held in an internal buffer until then.
module cmd_reply_packer #(
  parameter int IDLE_TIMEOUT = 16,
  parameter int PKT_WORDS    = 256
) (
  input  logic        rxclk,
  input  logic        reset,
  input  logic [31:0] timestamp_clock,
  input  logic        rx_WR,
  input  logic [15:0] rx_databus,
  input  logic        rx_WR_done,
  output logic        rx_WR_enabled,
  input  logic        have_space,
  output logic        wrreq,
  output logic [15:0] fifodata,
  output logic        overrun
);

  localparam int          BUF_WORDS = 252;
  localparam int          WCNT_W    = $clog2(PKT_WORDS);
  localparam int          IDLE_W    = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [7:0]  BUF_FULL  = 8'(BUF_WORDS);
  localparam logic [7:0]  LAST_LINE = 8'(BUF_WORDS - 2);
  localparam logic [4:0]  CTRL_CHAN = 5'h1F;

  typedef enum logic [2:0] {
    COLLECT,
    WAIT_SPACE,
    HDR_LO,
    HDR_HI,
    TS_LO,
    TS_HI,
    PAYLOAD,
    PAD
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic [7:0]          count;
  logic [IDLE_W-1:0]   idle_cnt;
  logic [31:0]         ts;
  logic [WCNT_W-1:0]   wcnt;
  logic [7:0]          rd_ptr;
  logic [15:0]         buf_mem [0:BUF_WORDS-1];

  logic                accept;
  logic                idle_inc;
  logic                idle_hit;
  logic                emitting;
  logic                last_word;
  logic                pkt_end;

  // A word is taken only while collecting and while the buffer has room;
  // anything else strobed by the reader is dropped and flagged.
  assign accept    = (state == COLLECT) && rx_WR && (count != BUF_FULL);

  // The idle counter only advances while the reader is quiet between commands
  // and there is something buffered worth flushing.
  assign idle_inc  = (state == COLLECT) && rx_WR_done && !rx_WR && (count != 8'd0);

  // Flush decision is taken on the cycle whose increment makes the counter
  // reach the timeout, so the packet leaves without an extra dead cycle.
  assign idle_hit  = idle_inc && (idle_cnt >= IDLE_W'(IDLE_TIMEOUT - 1));

  assign emitting  = (state != COLLECT) && (state != WAIT_SPACE);
  assign last_word = (wcnt == WCNT_W'(PKT_WORDS - 1));
  assign pkt_end   = ((state == PAYLOAD) || (state == PAD)) && last_word;

  // State register.
  always_ff @(posedge rxclk) begin
    if (reset) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: collect until full or idle on a line boundary, wait for room
  // downstream, then walk header, timestamp, payload and padding.
  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: begin
        // An odd count means the high half of a line is still due, so the
        // timeout never splits a line.
        if ((count == BUF_FULL) || (idle_hit && !count[0])) begin
          state_nxt = WAIT_SPACE;
        end
      end
      WAIT_SPACE: begin
        if (have_space) begin
          state_nxt = HDR_LO;
        end
      end
      HDR_LO:  state_nxt = HDR_HI;
      HDR_HI:  state_nxt = TS_LO;
      TS_LO:   state_nxt = TS_HI;
      TS_HI:   state_nxt = PAYLOAD;
      PAYLOAD: begin
        if (last_word) begin
          state_nxt = COLLECT;
        end else if (rd_ptr == (count - 8'd1)) begin
          state_nxt = PAD;
        end
      end
      PAD: begin
        if (last_word) begin
          state_nxt = COLLECT;
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // Outputs decoded from registered state: accept flag, FIFO strobe and data.
  always_comb begin
    rx_WR_enabled = (state == COLLECT) && (count <= LAST_LINE) && !count[0];
    wrreq         = emitting;
    fifodata      = 16'h0000;
    case (state)
      HDR_LO:  fifodata = {7'b0, count, 1'b0};
      HDR_HI:  fifodata = {11'b0, CTRL_CHAN};
      TS_LO:   fifodata = ts[15:0];
      TS_HI:   fifodata = ts[31:16];
      PAYLOAD: fifodata = buf_mem[rd_ptr];
      default: fifodata = 16'h0000;
    endcase
  end

  // Control registers: fill count, idle timer, timestamp, emission counters
  // and the sticky overrun flag.
  always_ff @(posedge rxclk) begin
    if (reset) begin
      count    <= 8'd0;
      idle_cnt <= '0;
      ts       <= 32'd0;
      wcnt     <= '0;
      rd_ptr   <= 8'd0;
      overrun  <= 1'b0;
    end else begin
      if (accept) begin
        count <= count + 8'd1;
        if (count == 8'd0) begin
          ts <= timestamp_clock;
        end
      end

      if (rx_WR || !rx_WR_done) begin
        idle_cnt <= '0;
      end else if (idle_inc && (idle_cnt < IDLE_W'(IDLE_TIMEOUT))) begin
        idle_cnt <= idle_cnt + 1'b1;
      end

      if (rx_WR && !accept) begin
        overrun <= 1'b1;
      end

      if (state == WAIT_SPACE) begin
        wcnt   <= '0;
        rd_ptr <= 8'd0;
      end else if (emitting) begin
        wcnt <= wcnt + 1'b1;
        if (state == PAYLOAD) begin
          rd_ptr <= rd_ptr + 8'd1;
        end
      end

      if (pkt_end) begin
        count    <= 8'd0;
        idle_cnt <= '0;
      end
    end
  end

  // Reply buffer: plain storage, written in arrival order.
  always_ff @(posedge rxclk) begin
    if (accept) begin
      buf_mem[count] <= rx_databus;
    end
  end

endmodule

// File: doc/cmd_reply_packer.md
# cmd_reply_packer

Receive-side counterpart to the command reader: it collects 16-bit control-reply words from the command reader (`rx_WR`/`rx_databus`) and frames them into 512-byte inband USB packets on the control channel (0x1F). Each packet carries a header, a timestamp and up to 252 payload words, and is zero-padded to 256 words. The block writes each packet into the RX-side packet FIFO toward the FX2 as 256 back-to-back 16-bit writes. Reply words are buffered internally, because the payload length is known only when the packet is closed.

## Interface
- `IDLE_TIMEOUT`, default 16: consecutive cycles of `rx_WR_done`=1 with no `rx_WR` and a non-empty buffer before a partial packet is flushed.
- `PKT_WORDS`, default 256: total 16-bit words per emitted packet (fixed 512-byte USB packet).

Ports:
- `rxclk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `timestamp_clock` in 32: free-running timestamp counter.
- `rx_WR` in 1: reply word strobe from the command reader.
- `rx_databus` in 16: reply word. Each reply line arrives as the low half, then the high half on the next cycle.
- `rx_WR_done` in 1: high while the command reader is between commands (not sending).
- `rx_WR_enabled` out 1: the packer can accept one reply line (2 words).
- `have_space` in 1: the downstream FIFO has at least `PKT_WORDS` free words.
- `wrreq` out 1: downstream FIFO write strobe.
- `fifodata` out 16: downstream FIFO write data.
- `overrun` out 1: sticky flag, set when `rx_WR` arrives while not accepting. Cleared only by `reset`.

## Operation
- Internal buffer: 252×16 words with write counter `count` (0..252).
- States: COLLECT, WAIT_SPACE, HDR_LO, HDR_HI, TS_LO, TS_HI, PAYLOAD, PAD.
- COLLECT:
  - Each `rx_WR`=1 stores `rx_databus` at `buf[count]` and increments `count`.
  - The first stored word of a packet latches `timestamp_clock` into `ts`.
  - `rx_WR_enabled` = (state==COLLECT) && `count`≤250 && `count` even. It is combinational from registered state.
  - An idle counter increments while `rx_WR_done`=1, `rx_WR`=0 and `count`>0. It clears on any `rx_WR` or when `rx_WR_done`=0.
- COLLECT → WAIT_SPACE when either condition holds:
  - `count`==252.
  - The idle counter reaches `IDLE_TIMEOUT` and `count` is even.
- `count`==0 never flushes; no empty packets are produced.
- WAIT_SPACE → HDR_LO when `have_space`=1. Otherwise it holds indefinitely with `rx_WR_enabled`=0.
- Emission: `wrreq`=1 every cycle from HDR_LO through the end of PAD, exactly `PKT_WORDS` words:
  - HDR_LO: header[15:0] = {7'b0, `count`×2 as a 9-bit byte length}.
  - HDR_HI: header[31:16] = {11'b0, 5'h1F}.
  - TS_LO: `ts`[15:0]. TS_HI: `ts`[31:16].
  - PAYLOAD: `buf[0..count-1]` in arrival order.
  - PAD: 0x0000 until the 256th word.
- After the last PAD word: `count`←0, idle counter←0, state→COLLECT.
- `rx_WR`=1 in any state other than COLLECT, or with `count`==252: the word is dropped and `overrun`←1.

## Timing
- Reset values:
  - `rx_WR_enabled`=1 (COLLECT, `count`=0).
  - `wrreq`=0, `fifodata`=0, `overrun`=0.
  - `count`=0, idle counter=0, `ts`=0.
- Reset mid-emission: `wrreq`=0 from the next cycle, and the partial packet is abandoned. Downstream FIFO cleanup is not this block's job.
- A write strobed at cycle t is stored at the t edge; `count` and `rx_WR_enabled` reflect it at t+1.
- The command reader writes a high half unconditionally one cycle after a low half. The even-count rule guarantees both halves land; a flush never splits a line.
- Full flush: `count` becomes 252 at edge t, WAIT_SPACE at t+1; with `have_space`=1, the first `wrreq` is at t+2. The same latency applies after the timeout is reached.
- Emission lasts exactly 256 consecutive cycles. `have_space` is not re-checked mid-packet.
- Width rules: the byte length is 9 bits, max 504. `ts` is 32-bit with no wrap handling; it is copied verbatim.
- Simultaneous timeout and `rx_WR` in the same cycle: the word is stored and the timeout clears; no flush that cycle.

## Test plan
- Ping reply: 0x0010 then 0x0102 on consecutive `rx_WR`, `rx_WR_done`=1, `timestamp_clock` = 0x00ABCDEF at the first word, `IDLE_TIMEOUT`=16. Required: the packet starts 18 cycles after the last write, and its words are 0x0004, 0x001F, 0xCDEF, 0x00AB, 0x0010, 0x0102, then 250×0x0000.
- Fill: 126 lines (252 words, values 0..251) streamed continuously. Required: `rx_WR_enabled` drops after `count`=250 is observed; header low word = 0x01F8; payload words 0..251; no PAD words.
- Back-pressure: full buffer with `have_space`=0 for 100 cycles. Required: `wrreq`=0 and `rx_WR_enabled`=0 throughout. `rx_WR` injected during this window sets `overrun`. When `have_space` rises, emission starts on the next cycle.
- Timeout reset: 2 words written, then `rx_WR_done` toggled low once every 10 cycles. Required: no flush. A new line extends the same packet to a header length of 8.
- Reset during PAYLOAD (word 40 of 256). Required: `wrreq`=0 the next cycle, `count`=0, `rx_WR_enabled`=1, `overrun`=0. The next packet is well-formed.
- Back-to-back packets: 300 words offered continuously. Required: the first packet has 252 words; the second collects the remainder after COLLECT resumes. The second timestamp is latched at its own first word.
